// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR filter: FSM encoding,
// width helpers and the output saturation helpers.
package fir_pkg;

    // Working width for the saturation helpers; must exceed any accumulator width in use.
    localparam int SAT_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_IN  = 2'd1,
        MAC     = 2'd2,
        REQ_OUT = 2'd3
    } fir_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int fir_awidth(input int dwidth, input int nr_taps);
        return 2 * dwidth + clog2(nr_taps);
    endfunction

    // True when s does not fit in a signed owidth-bit field.
    function automatic logic fir_overflow(input logic [SAT_W-1:0] s, input int owidth);
        logic ovf;
        ovf = 1'b0;
        for (int i = 0; i < SAT_W; i++) begin
            if (i >= owidth - 1 && s[i] != s[SAT_W-1]) begin
                ovf = 1'b1;
            end
        end
        return ovf;
    endfunction

    // Clamp s to the signed owidth-bit range; the caller keeps the low owidth bits.
    function automatic logic [SAT_W-1:0] fir_saturate(input logic [SAT_W-1:0] s, input int owidth);
        logic [SAT_W-1:0] top_bit;
        top_bit = {{(SAT_W-1){1'b0}}, 1'b1} << (owidth - 1);
        if (!fir_overflow(s, owidth)) begin
            return s;
        end else if (s[SAT_W-1]) begin
            return top_bit;
        end else begin
            return top_bit - 1'b1;
        end
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with output shift and conversion.
// Optional clamp on overflow when FIR_SATURATE_EN is defined.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 37,
    parameter int OWIDTH = 32,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     last,
    input  logic signed [DWIDTH-1:0] x,
    input  logic signed [DWIDTH-1:0] h,
    output logic        [OWIDTH-1:0] data_out
);

    logic signed [2*DWIDTH-1:0] prod;
    logic signed [AWIDTH-1:0]   acc_reg;
    logic signed [AWIDTH-1:0]   sum;
    logic        [OWIDTH-1:0]   data_next;
    logic                       ovf_next;
    logic                       ovf_reg;

    always_comb begin
        prod = x * h;
        sum  = acc_reg + {{(AWIDTH-2*DWIDTH){prod[2*DWIDTH-1]}}, prod};
    end

`ifdef FIR_SATURATE_EN
    logic signed [AWIDTH-1:0] shifted;
    logic        [SAT_W-1:0]  shifted_ext;

    always_comb begin
        shifted     = sum >>> SHIFT;
        shifted_ext = {{(SAT_W-AWIDTH){shifted[AWIDTH-1]}}, shifted};
        ovf_next    = fir_overflow(shifted_ext, OWIDTH);
        data_next   = OWIDTH'(fir_saturate(shifted_ext, OWIDTH));
    end
`else
    always_comb begin
        ovf_next  = 1'b0;
        data_next = OWIDTH'(sum >>> SHIFT);
    end
`endif

    // ovf_reg is sticky: set by any clamped output since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            data_out <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            if (clr) begin
                acc_reg <= '0;
            end else if (en) begin
                acc_reg <= sum;
            end
            if (last) begin
                data_out <= data_next;
                ovf_reg  <= ovf_reg | ovf_next;
            end
        end
    end

endmodule

// File: rtl/fir_filter_seq.sv
// Time-multiplexed FIR filter: delay line, tap sequencer and req/ack handshakes
// around a single shared MAC. Build option: FIR_SATURATE_EN (output clamp).
module fir_filter_seq
    import fir_pkg::*;
#(
    parameter int NR_TAPS = 32,
    parameter int DWIDTH  = 16,
    parameter int CWIDTH  = NR_TAPS * DWIDTH,
    parameter int OWIDTH  = 2 * DWIDTH,
    parameter int SHIFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_in,
    input  logic              ack_in,
    input  logic [0:DWIDTH-1] data_in,
    output logic              req_out,
    input  logic              ack_out,
    output logic [0:OWIDTH-1] data_out,
    input  logic [0:CWIDTH-1] h_in
);

    localparam int AWIDTH = fir_awidth(DWIDTH, NR_TAPS);
    localparam int CNT_W  = clog2(NR_TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NR_TAPS - 1);

    fir_state_t               state_reg;
    fir_state_t               state_next;
    logic [CNT_W-1:0]         tap_reg;
    logic signed [DWIDTH-1:0] x_reg [NR_TAPS];
    logic signed [DWIDTH-1:0] h_tap [NR_TAPS];
    logic                     in_fire;
    logic                     mac_en;
    logic                     mac_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = REQ_IN;
            REQ_IN:  if (ack_in) state_next = MAC;
            MAC:     if (tap_reg == LAST_TAP) state_next = REQ_OUT;
            REQ_OUT: if (ack_out) state_next = REQ_IN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_in   = (state_reg == REQ_IN);
        req_out  = (state_reg == REQ_OUT);
        mac_en   = (state_reg == MAC);
        mac_last = mac_en && (tap_reg == LAST_TAP);
        in_fire  = req_in && ack_in;
    end

    // Counter returns to 0 after the last tap so the index never leaves the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_reg <= '0;
        end else if (in_fire || mac_last) begin
            tap_reg <= '0;
        end else if (mac_en) begin
            tap_reg <= tap_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR_TAPS; i++) begin
                x_reg[i] <= '0;
            end
        end else if (in_fire) begin
            x_reg[0] <= data_in;
            for (int i = 1; i < NR_TAPS; i++) begin
                x_reg[i] <= x_reg[i-1];
            end
        end
    end

    // Tap 0 is the leftmost coefficient field of h_in.
    generate
        for (genvar gi = 0; gi < NR_TAPS; gi++) begin : g_coef
            assign h_tap[gi] = h_in[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    fir_mac #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .OWIDTH (OWIDTH),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (in_fire),
        .en       (mac_en),
        .last     (mac_last),
        .x        (x_reg[tap_reg]),
        .h        (h_tap[tap_reg]),
        .data_out (data_out)
    );

endmodule
